// File: rtl/ram_wr_arb_pkg.sv
// Shared types and width helpers for the RAM write-port arbiter.
// The state enum and clog2 are used by both the arbiter top and its selector.
package ram_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Smallest w with 2**w >= value; elaboration-time only.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or above
// i_ptr, searching upward and wrapping modulo N.
module rr_arbiter
    import ram_wr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        logic [IW-1:0] w_cand;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // N is a power of two, so IW-bit addition wraps the search for free.
        for (int k = 0; k < N; k++) begin
            w_cand = i_ptr + IW'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Round-robin, burst-locked sharing of one RAM write port between NUM_REQ
// requesters, each owning a fixed address segment with a circular pointer.
module ram_wr_arbiter
    import ram_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int IDX_W      = clog2(NUM_REQ),
    parameter int SEG_W      = ADDR_WIDTH - IDX_W
) (
    input  logic                          w_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            ptr_clr,
    output logic                          ram_w_en,
    output logic [ADDR_WIDTH-1:0]         ram_w_addr,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    output logic [NUM_REQ*SEG_W-1:0]      wr_ptr,
    output logic [NUM_REQ-1:0]            wrap_pulse,
    output logic                          busy
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_grant;
    logic [NUM_REQ-1:0]     r_grant_oh;
    logic [IDX_W-1:0]       r_prio;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [SEG_W-1:0]       r_ptr [NUM_REQ];
    logic                   r_w_en;
    logic [ADDR_WIDTH-1:0]  r_w_addr;
    logic [DATA_WIDTH-1:0]  r_w_data;
    logic [NUM_REQ-1:0]     r_wrap;

    logic [NUM_REQ-1:0]     w_arb_oh;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_any;
    logic [DATA_WIDTH-1:0]  w_req_data [NUM_REQ];
    logic [SEG_W-1:0]       w_cur_ptr;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_burst_end;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_prio),
        .o_grant (w_arb_oh),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g]               = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign wr_ptr[g*SEG_W +: SEG_W]    = r_ptr[g];
    end

    assign w_cur_ptr   = r_ptr[r_grant];
    assign w_accept    = (r_state == BURST) && req_valid[r_grant];
    assign w_cnt_nxt   = r_beat_cnt + CNT_W'(1);
    assign w_burst_end = req_last[r_grant] || (w_cnt_nxt == CNT_W'(MAX_BURST));

    // Ready comes only from registered state so requesters never see a loop
    // through their own valid.
    assign req_ready   = (r_state == BURST) ? r_grant_oh : '0;
    assign busy        = (r_state == BURST);

    assign ram_w_en    = r_w_en;
    assign ram_w_addr  = r_w_addr;
    assign ram_data_in = r_w_data;
    assign wrap_pulse  = r_wrap;

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_prio     <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_oh;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_nxt;
                        if (w_burst_end) begin
                            r_state <= IDLE;
                            r_prio  <= r_grant + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write stage: one registered cycle between accept and the RAM port.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
            r_wrap   <= '0;
        end else begin
            r_w_en <= w_accept;
            r_wrap <= '0;
            if (w_accept) begin
                r_w_addr <= {r_grant, w_cur_ptr};
                r_w_data <= w_req_data[r_grant];
                if ((&w_cur_ptr) && !ptr_clr[r_grant]) begin
                    r_wrap[r_grant] <= 1'b1;
                end
            end
        end
    end

    // A clear wins over a coincident increment; the write itself already
    // captured the pre-clear pointer above.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ptr_clr[i]) begin
                    r_ptr[i] <= '0;
                end else if (w_accept && (r_grant == IDX_W'(i))) begin
                    r_ptr[i] <= r_ptr[i] + SEG_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Bench for ram_wr_arbiter: reactive per-requester beat drivers, a
// transaction-level model checked every cycle, and literal write-log checks.
module tb_ram_wr_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int SW = 8;

    logic                 w_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_last = '0;
    logic [NR*DW-1:0]     req_data = '0;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        ptr_clr = '0;
    logic                 ram_w_en;
    logic [AW-1:0]        ram_w_addr;
    logic [DW-1:0]        ram_data_in;
    logic [NR*SW-1:0]     wr_ptr;
    logic [NR-1:0]        wrap_pulse;
    logic                 busy;

    always #5 w_clk = ~w_clk;

    ram_wr_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .w_clk       (w_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ptr_clr     (ptr_clr),
        .ram_w_en    (ram_w_en),
        .ram_w_addr  (ram_w_addr),
        .ram_data_in (ram_data_in),
        .wr_ptr      (wr_ptr),
        .wrap_pulse  (wrap_pulse),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requester drivers ----------------
    int rem [NR];
    int seq [NR];
    int lmode [NR];   // 0: never last, 1: last on final beat, 2: last on every beat
    bit acc [NR];

    initial begin
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; seq[i] = 0; lmode[i] = 0; acc[i] = 1'b0;
        end
        forever begin
            @(negedge w_clk);
            for (int i = 0; i < NR; i++) acc[i] = rst_n && req_valid[i] && req_ready[i];
            @(posedge w_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && rem[i] > 0) begin
                    rem[i]--;
                    seq[i]++;
                end
                req_valid[i] = (rem[i] > 0);
                req_last[i]  = (rem[i] > 0) && ((lmode[i] == 2) || (lmode[i] == 1 && rem[i] == 1));
                req_data[i*DW +: DW] = 32'hD000_0000 | (32'(i) << 16) | 32'(seq[i]);
            end
        end
    end

    // ---------------- behavioural model ----------------
    int            m_busy = 0, m_grant = 0, m_prio = 0, m_cnt = 0;
    int            m_ptr [NR];
    bit            e_wen = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [NR-1:0] e_wrap = '0;

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_prio = 0; m_cnt = 0;
        for (int i = 0; i < NR; i++) m_ptr[i] = 0;
        e_wen = 1'b0; e_addr = '0; e_data = '0; e_wrap = '0;
    endtask

    task automatic model_step();
        int g;
        bit a;
        bit found;
        g = m_grant;
        a = (m_busy != 0) && req_valid[g];
        e_wen  = a;
        e_wrap = '0;
        if (a) begin
            e_addr = AW'(g * (1 << SW) + m_ptr[g]);
            e_data = req_data[g*DW +: DW];
            if (m_ptr[g] == (1 << SW) - 1 && !ptr_clr[g]) e_wrap[g] = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            if (ptr_clr[i]) m_ptr[i] = 0;
            else if (a && i == g) m_ptr[i] = (m_ptr[i] + 1) % (1 << SW);
        end
        if (m_busy == 0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && req_valid[(m_prio + k) % NR]) begin
                    found   = 1'b1;
                    m_grant = (m_prio + k) % NR;
                    m_cnt   = 0;
                    m_busy  = 1;
                end
            end
        end else if (a) begin
            m_cnt++;
            if (req_last[g] || m_cnt == MB) begin
                m_busy = 0;
                m_prio = (g + 1) % NR;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge w_clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    logic [NR-1:0] log_wrap [$];
    int            log_cyc  [$];

    initial begin
        logic [NR*SW-1:0] e_ptr;
        forever begin
            @(negedge w_clk);
            if (cmp_en) begin
                for (int i = 0; i < NR; i++) e_ptr[i*SW +: SW] = SW'(m_ptr[i]);
                check("ram_w_en", 64'(ram_w_en), 64'(e_wen));
                check("req_ready", 64'(req_ready), 64'((m_busy != 0) ? (1 << m_grant) : 0));
                check("busy", 64'(busy), 64'(m_busy != 0));
                check("wrap_pulse", 64'(wrap_pulse), 64'(e_wrap));
                check("wr_ptr", 64'(wr_ptr), 64'(e_ptr));
                if (e_wen) begin
                    check("ram_w_addr", 64'(ram_w_addr), 64'(e_addr));
                    check("ram_data_in", 64'(ram_data_in), 64'(e_data));
                end
            end
            if (rst_n && ram_w_en) begin
                log_addr.push_back(ram_w_addr);
                log_data.push_back(ram_data_in);
                log_wrap.push_back(wrap_pulse);
                log_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge w_clk);
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_wrap.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ptr_clr = '0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; seq[i] = 0; lmode[i] = 0;
        end
        step(3);
        rst_n = 1'b1;
        clear_log();
        step(1);
    endtask

    task automatic load(input int i, input int n, input int lm);
        rem[i] = n;
        lmode[i] = lm;
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NR; i++) if (rem[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        while (pending() && t < budget) begin
            step(1);
            t++;
        end
        check(name, 64'(pending()), 64'(0));
        step(3);
    endtask

    function automatic int wraps_in_log();
        int c;
        c = 0;
        foreach (log_wrap[k]) if (log_wrap[k] != '0) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int exp4 [13];
        int t;
        exp4 = '{'h100, 'h101, 'h102, 'h103, 'h104, 'h105, 'h106, 'h107,
                 'h300, 'h108, 'h109, 'h10A, 'h10B};

        step(3);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_w_en", 64'(ram_w_en), 64'(0));
        check("rst_addr", 64'(ram_w_addr), 64'(0));
        check("rst_data", 64'(ram_data_in), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_wrptr", 64'(wr_ptr), 64'(0));
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Idle after reset
        do_reset();
        step(20);
        check("idle_writes", 64'(log_addr.size()), 64'(0));
        check("idle_wrptr", 64'(wr_ptr), 64'(0));

        // Single 3-beat burst from requester 2
        do_reset();
        load(2, 3, 1);
        drain("t2_drain", 50);
        check("t2_count", 64'(log_addr.size()), 64'(3));
        if (log_addr.size() == 3) begin
            check("t2_addr0", 64'(log_addr[0]), 64'h200);
            check("t2_addr1", 64'(log_addr[1]), 64'h201);
            check("t2_addr2", 64'(log_addr[2]), 64'h202);
            check("t2_data0", 64'(log_data[0]), 64'hD002_0000);
            check("t2_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'(1));
            check("t2_gap12", 64'(log_cyc[2] - log_cyc[1]), 64'(1));
        end
        check("t2_wrptr2", 64'(wr_ptr[2*SW +: SW]), 64'h03);
        check("t2_idle", 64'(busy), 64'(0));

        // All requesting single-beat bursts: round robin with one bubble
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 2, 2);
        drain("t3_drain", 100);
        check("t3_count", 64'(log_addr.size()), 64'(8));
        if (log_addr.size() == 8) begin
            check("t3_addr0", 64'(log_addr[0]), 64'h000);
            check("t3_addr1", 64'(log_addr[1]), 64'h100);
            check("t3_addr2", 64'(log_addr[2]), 64'h200);
            check("t3_addr3", 64'(log_addr[3]), 64'h300);
            check("t3_addr4", 64'(log_addr[4]), 64'h001);
            check("t3_bubble", 64'(log_cyc[1] - log_cyc[0]), 64'(2));
        end

        // Forced rearbitration after MAX_BURST beats
        do_reset();
        load(1, 12, 0);
        load(3, 1, 1);
        drain("t4_drain", 100);
        check("t4_count", 64'(log_addr.size()), 64'(13));
        if (log_addr.size() == 13) begin
            for (int k = 0; k < 13; k++) check($sformatf("t4_addr%0d", k), 64'(log_addr[k]), 64'(exp4[k]));
        end

        // Pointer wrap of requester 0
        do_reset();
        load(0, 257, 0);
        drain("t5_drain", 600);
        check("t5_count", 64'(log_addr.size()), 64'(257));
        if (log_addr.size() == 257) begin
            check("t5_addr255", 64'(log_addr[255]), 64'h0FF);
            check("t5_wrap255", 64'(log_wrap[255]), 64'b0001);
            check("t5_addr256", 64'(log_addr[256]), 64'h000);
            check("t5_wrap256", 64'(log_wrap[256]), 64'b0000);
        end
        check("t5_wrapcnt", 64'(wraps_in_log()), 64'(1));
        check("t5_wrptr0", 64'(wr_ptr[0 +: SW]), 64'h01);

        // Pointer clear coinciding with an accepted beat
        do_reset();
        load(1, 5, 1);
        drain("t6a_drain", 50);
        load(1, 3, 1);
        t = 0;
        step(1);
        while (!(busy && req_ready[1] && req_valid[1] && wr_ptr[SW +: SW] == 8'h05) && t < 20) begin
            step(1);
            t++;
        end
        check("t6_sync_timeout", 64'(t >= 20), 64'(0));
        ptr_clr[1] = 1'b1;
        step(1);
        ptr_clr[1] = 1'b0;
        check("t6_ptr_after_clr", 64'(wr_ptr[SW +: SW]), 64'h00);
        drain("t6b_drain", 50);
        check("t6_count", 64'(log_addr.size()), 64'(8));
        if (log_addr.size() == 8) begin
            check("t6_addr5", 64'(log_addr[5]), 64'h105);
            check("t6_addr6", 64'(log_addr[6]), 64'h100);
            check("t6_addr7", 64'(log_addr[7]), 64'h101);
        end
        check("t6_nowrap", 64'(wraps_in_log()), 64'(0));

        // Reset asserted mid-burst
        load(2, 20, 0);
        step(5);
        check("t7_busy_before", 64'(busy), 64'(1));
        check("t7_wen_before", 64'(ram_w_en), 64'(1));
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        #1;
        check("t7_wen", 64'(ram_w_en), 64'(0));
        check("t7_ready", 64'(req_ready), 64'(0));
        check("t7_busy", 64'(busy), 64'(0));
        check("t7_wrptr", 64'(wr_ptr), 64'(0));
        step(2);
        rst_n = 1'b1;
        clear_log();
        step(5);
        check("t7_no_writes", 64'(log_addr.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
